// File: rtl/directory_controller_if.sv
// directory_controller_if: bus, invalidate, fetch and reply handshakes of the MSI home directory
interface directory_controller_if #(
    parameter int NUM_NODES = 4,
    parameter int NODE_W    = 2,
    parameter int BLOCK_W   = 3
);
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_type;
    logic [NODE_W-1:0]    req_node;
    logic [BLOCK_W-1:0]   req_block;
    logic                 inv_valid;
    logic [NUM_NODES-1:0] inv_mask;
    logic                 inv_ack;
    logic                 fetch_valid;
    logic [NODE_W-1:0]    fetch_node;
    logic                 fetch_invalidate;
    logic                 fetch_ack;
    logic                 mem_wb;
    logic                 reply_valid;
    logic [NODE_W-1:0]    reply_node;
    logic                 reply_exclusive;
    logic                 reply_ready;

    modport master (
        output req_valid, req_type, req_node, req_block, inv_ack, fetch_ack, reply_ready,
        input  req_ready, inv_valid, inv_mask, fetch_valid, fetch_node, fetch_invalidate,
               mem_wb, reply_valid, reply_node, reply_exclusive
    );

    modport slave (
        input  req_valid, req_type, req_node, req_block, inv_ack, fetch_ack, reply_ready,
        output req_ready, inv_valid, inv_mask, fetch_valid, fetch_node, fetch_invalidate,
               mem_wb, reply_valid, reply_node, reply_exclusive
    );
endinterface

// File: rtl/directory_controller.sv
// directory_controller: MSI home-node directory, one request in flight, per-block state plus sharer vector
module directory_controller #(
    parameter int NUM_NODES  = 4,
    parameter int NODE_W     = 2,
    parameter int NUM_BLOCKS = 8,
    parameter int BLOCK_W    = 3
) (
    input logic clock,
    input logic reset,
    directory_controller_if.slave bus
);
    localparam logic [1:0] UNCACHED  = 2'b01;
    localparam logic [1:0] SHARED    = 2'b10;
    localparam logic [1:0] EXCLUSIVE = 2'b11;
    localparam logic [1:0] WRITE_BACK = 2'b00;
    localparam logic [1:0] READ_MISS  = 2'b01;

    typedef enum logic [2:0] {IDLE, LOOKUP, INVAL, FETCH, REPLY} ctrlState_e;

    ctrlState_e           ctrl;
    logic [1:0]           entState   [NUM_BLOCKS];
    logic [NUM_NODES-1:0] entSharers [NUM_BLOCKS];
    logic [1:0]           reqType;
    logic [NODE_W-1:0]    reqNode;
    logic [BLOCK_W-1:0]   reqBlock;
    logic [1:0]           pendState;
    logic [NUM_NODES-1:0] pendSharers;
    logic                 reqReady;
    logic                 invValid;
    logic [NUM_NODES-1:0] invMask;
    logic                 fetchValid;
    logic [NODE_W-1:0]    fetchNode;
    logic                 fetchInv;
    logic                 replyValid;
    logic [NODE_W-1:0]    replyNode;
    logic                 replyExcl;

    logic [1:0]           curState;
    logic [NUM_NODES-1:0] curSharers;
    logic [NUM_NODES-1:0] reqBit;
    logic [NUM_NODES-1:0] others;
    logic [NODE_W-1:0]    ownerId;
    logic                 isRead;
    logic                 isWb;
    logic                 wbHit;
    logic                 needFetch;
    logic                 needInval;
    logic [1:0]           nextState;
    logic [NUM_NODES-1:0] nextSharers;

    // Decode the latched request against its directory entry; only consumed in LOOKUP.
    // INVALIDATE needs no case of its own: with R a sharer it invalidates the other sharers,
    // and every other case is a write miss, which produces exactly the same actions.
    always_comb begin
        curState    = entState[reqBlock];
        curSharers  = entSharers[reqBlock];
        reqBit      = NUM_NODES'(1) << reqNode;
        others      = curSharers & ~reqBit;
        ownerId     = '0;
        for (int i = 0; i < NUM_NODES; i++)
            if (curSharers[i]) ownerId = NODE_W'(i);
        isRead      = reqType == READ_MISS;
        isWb        = reqType == WRITE_BACK;
        wbHit       = isWb && curState == EXCLUSIVE && curSharers == reqBit;
        needFetch   = curState == EXCLUSIVE && (isRead || curSharers != reqBit);
        needInval   = !isRead && curState == SHARED && others != '0;
        nextState   = isRead ? SHARED : EXCLUSIVE;
        nextSharers = isRead ? (curSharers | reqBit) : reqBit;
    end

    // Controller FSM with registered handshake outputs; the entry is committed on entry to REPLY
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl        <= IDLE;
            reqReady    <= 1'b1;
            invValid    <= 1'b0;
            invMask     <= '0;
            fetchValid  <= 1'b0;
            fetchNode   <= '0;
            fetchInv    <= 1'b0;
            replyValid  <= 1'b0;
            replyNode   <= '0;
            replyExcl   <= 1'b0;
            reqType     <= '0;
            reqNode     <= '0;
            reqBlock    <= '0;
            pendState   <= UNCACHED;
            pendSharers <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                entState[i]   <= UNCACHED;
                entSharers[i] <= '0;
            end
        end else begin
            case (ctrl)
                IDLE: if (bus.req_valid) begin
                    reqType  <= bus.req_type;
                    reqNode  <= bus.req_node;
                    reqBlock <= bus.req_block;
                    reqReady <= 1'b0;
                    ctrl     <= LOOKUP;
                end
                LOOKUP: begin
                    pendState   <= nextState;
                    pendSharers <= nextSharers;
                    replyNode   <= reqNode;
                    replyExcl   <= !isRead;
                    if (isWb) begin
                        if (wbHit) begin
                            entState[reqBlock]   <= UNCACHED;
                            entSharers[reqBlock] <= '0;
                        end
                        reqReady <= 1'b1;
                        ctrl     <= IDLE;
                    end else if (needFetch) begin
                        fetchValid <= 1'b1;
                        fetchNode  <= ownerId;
                        fetchInv   <= !isRead;
                        ctrl       <= FETCH;
                    end else if (needInval) begin
                        invValid <= 1'b1;
                        invMask  <= others;
                        ctrl     <= INVAL;
                    end else begin
                        replyValid           <= 1'b1;
                        entState[reqBlock]   <= nextState;
                        entSharers[reqBlock] <= nextSharers;
                        ctrl                 <= REPLY;
                    end
                end
                INVAL: if (bus.inv_ack) begin
                    invValid             <= 1'b0;
                    invMask              <= '0;
                    replyValid           <= 1'b1;
                    entState[reqBlock]   <= pendState;
                    entSharers[reqBlock] <= pendSharers;
                    ctrl                 <= REPLY;
                end
                FETCH: if (bus.fetch_ack) begin
                    fetchValid           <= 1'b0;
                    fetchNode            <= '0;
                    fetchInv             <= 1'b0;
                    replyValid           <= 1'b1;
                    entState[reqBlock]   <= pendState;
                    entSharers[reqBlock] <= pendSharers;
                    ctrl                 <= REPLY;
                end
                REPLY: if (bus.reply_ready) begin
                    replyValid <= 1'b0;
                    replyNode  <= '0;
                    replyExcl  <= 1'b0;
                    reqReady   <= 1'b1;
                    ctrl       <= IDLE;
                end
                default: ctrl <= IDLE;
            endcase
        end
    end

    // mem_wb is decoded rather than registered so it lands in LOOKUP (write-back) or in the
    // fetch_ack cycle, both strictly before any reply_valid of the same transaction
    assign bus.mem_wb = (ctrl == LOOKUP && wbHit) || (ctrl == FETCH && fetchValid && bus.fetch_ack);

    assign bus.req_ready        = reqReady;
    assign bus.inv_valid        = invValid;
    assign bus.inv_mask         = invMask;
    assign bus.fetch_valid      = fetchValid;
    assign bus.fetch_node       = fetchNode;
    assign bus.fetch_invalidate = fetchInv;
    assign bus.reply_valid      = replyValid;
    assign bus.reply_node       = replyNode;
    assign bus.reply_exclusive  = replyExcl;
endmodule

// File: tb/tb_directory_controller.sv
// tb_directory_controller: directed MSI directory scenarios with a queue-based scoreboard monitor
module tb_directory_controller;
    localparam logic [1:0] WB  = 2'b00;
    localparam logic [1:0] RM  = 2'b01;
    localparam logic [1:0] WM  = 2'b10;
    localparam logic [1:0] INV = 2'b11;
    localparam int EV_INV = 0, EV_FETCH = 1, EV_MEMWB = 2, EV_REPLY = 3;

    typedef struct {
        int         kind;
        logic [3:0] a;
        logic       b;
        int         lat;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cycleCnt = 0;
    int   acceptCnt = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  sbq[$];

    directory_controller_if #(.NUM_NODES(4), .NODE_W(2), .BLOCK_W(3)) bus();

    directory_controller #(.NUM_NODES(4), .NODE_W(2), .NUM_BLOCKS(8), .BLOCK_W(3)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clock = ~clock;

    // Free-running cycle count used for latency checks
    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycleCnt);
        end
    endtask

    task automatic push(input int kind, input logic [3:0] a, input logic b, input int lat);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        e.lat  = lat;
        sbq.push_back(e);
    endtask

    task automatic expInv(input logic [3:0] mask);                 push(EV_INV, mask, 1'b0, 0);           endtask
    task automatic expFetch(input int node, input logic inv);      push(EV_FETCH, 4'(node), inv, 0);      endtask
    task automatic expWb();                                        push(EV_MEMWB, 4'd0, 1'b0, 0);         endtask
    task automatic expReply(input int node, input logic ex, input int lat); push(EV_REPLY, 4'(node), ex, lat); endtask

    task automatic popCmp(input int kind, input logic [3:0] a, input logic b);
        ev_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected event: got kind %0d payload %0h/%0b, expected nothing", kind, a, b);
        end else begin
            e = sbq.pop_front();
            chk("event kind", kind, e.kind);
            chk("event payload", int'(a), int'(e.a));
            chk("event flag", int'(b), int'(e.b));
            if (e.lat > 0) chk("reply latency", cycleCnt - acceptCnt, e.lat);
        end
    endtask

    logic       pInv = 1'b0, pFetch = 1'b0, pReply = 1'b0;
    logic [3:0] hMask;
    logic [1:0] hFNode, hRNode;
    logic       hFInv, hRExcl;

    // Monitor: pops an expectation whenever a handshake rises or mem_wb pulses; checks held payloads
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.inv_valid && !pInv) popCmp(EV_INV, bus.inv_mask, 1'b0);
            if (bus.inv_valid && pInv) chk("inv_mask stable", int'(bus.inv_mask), int'(hMask));
            if (bus.fetch_valid && !pFetch) popCmp(EV_FETCH, 4'(bus.fetch_node), bus.fetch_invalidate);
            if (bus.fetch_valid && pFetch) chk("fetch stable", int'({bus.fetch_node, bus.fetch_invalidate}), int'({hFNode, hFInv}));
            if (bus.mem_wb) begin
                popCmp(EV_MEMWB, 4'd0, 1'b0);
                chk("mem_wb with reply_valid", int'(bus.reply_valid), 0);
            end
            if (bus.reply_valid && !pReply) popCmp(EV_REPLY, 4'(bus.reply_node), bus.reply_exclusive);
            if (bus.reply_valid && pReply) begin
                chk("reply stable", int'({bus.reply_node, bus.reply_exclusive}), int'({hRNode, hRExcl}));
                chk("req_ready low while replying", int'(bus.req_ready), 0);
            end
        end
        pInv   <= bus.inv_valid;
        pFetch <= bus.fetch_valid;
        pReply <= bus.reply_valid;
        hMask  <= bus.inv_mask;
        hFNode <= bus.fetch_node;
        hFInv  <= bus.fetch_invalidate;
        hRNode <= bus.reply_node;
        hRExcl <= bus.reply_exclusive;
    end

    task automatic checkIdle(input string tag);
        chk({tag, " req_ready"}, int'(bus.req_ready), 1);
        chk({tag, " inv/fetch"}, int'({bus.inv_valid, bus.inv_mask, bus.fetch_valid, bus.fetch_node, bus.fetch_invalidate}), 0);
        chk({tag, " reply/mem_wb"}, int'({bus.mem_wb, bus.reply_valid, bus.reply_node, bus.reply_exclusive}), 0);
    endtask

    task automatic sendReq(input logic [1:0] t, input int node, input int blk);
        int cyc = 0;
        while (!bus.req_ready && cyc < 50) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk("req_ready before send", int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_type  = t;
        bus.req_node  = 2'(node);
        bus.req_block = 3'(blk);
        @(posedge clock); #1;
        acceptCnt     = cycleCnt - 1;
        bus.req_valid = 1'b0;
    endtask

    // Issue one request and service its handshakes until the controller is back in IDLE
    task automatic doTxn(input logic [1:0] t, input int node, input int blk, input int ackDly, input int hold);
        int cyc = 0, invSeen = 0, fetchSeen = 0, held = 0;
        sendReq(t, node, blk);
        while (!bus.req_ready && cyc < 60) begin
            bus.inv_ack     = bus.inv_valid && invSeen >= ackDly;
            bus.fetch_ack   = bus.fetch_valid && fetchSeen >= ackDly;
            bus.reply_ready = bus.reply_valid && held >= hold;
            if (bus.inv_valid) invSeen++;
            if (bus.fetch_valid) fetchSeen++;
            if (bus.reply_valid) held++;
            @(posedge clock); #1;
            cyc++;
        end
        bus.inv_ack     = 1'b0;
        bus.fetch_ack   = 1'b0;
        bus.reply_ready = 1'b0;
        chk("transaction completes", int'(bus.req_ready), 1);
    endtask

    initial begin
        int cyc;
        bus.req_valid   = 1'b0;
        bus.req_type    = 2'b00;
        bus.req_node    = 2'd0;
        bus.req_block   = 3'd0;
        bus.inv_ack     = 1'b0;
        bus.fetch_ack   = 1'b0;
        bus.reply_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checkIdle("reset");
        @(posedge clock); #1;

        expReply(1, 1'b0, 2);                               doTxn(RM, 1, 3, 0, 0);
        expReply(2, 1'b0, 2);                               doTxn(RM, 2, 3, 0, 0);
        expInv(4'b0110); expReply(0, 1'b1, 0);              doTxn(WM, 0, 3, 3, 0);
        expFetch(0, 1'b0); expWb(); expReply(3, 1'b0, 0);   doTxn(RM, 3, 3, 2, 0);
        expInv(4'b0001); expReply(3, 1'b1, 0);              doTxn(INV, 3, 3, 0, 0);
        expWb();                                            doTxn(WB, 3, 3, 0, 0);
        doTxn(WB, 2, 3, 0, 0);
        expReply(2, 1'b0, 2);                               doTxn(RM, 2, 3, 0, 0);

        expReply(1, 1'b1, 2);                               doTxn(WM, 1, 5, 0, 0);
        doTxn(WB, 2, 5, 0, 0);
        expFetch(1, 1'b0); expWb(); expReply(0, 1'b0, 0);   doTxn(RM, 0, 5, 0, 0);
        expInv(4'b0001); expReply(1, 1'b1, 0);              doTxn(WM, 1, 5, 1, 0);
        expReply(1, 1'b1, 2);                               doTxn(WM, 1, 5, 0, 0);
        expFetch(1, 1'b1); expWb(); expReply(3, 1'b1, 0);   doTxn(WM, 3, 5, 0, 0);
        expFetch(3, 1'b1); expWb(); expReply(0, 1'b1, 0);   doTxn(INV, 0, 5, 0, 0);

        expReply(2, 1'b0, 2);                               doTxn(RM, 2, 6, 0, 5);

        expFetch(0, 1'b0);
        sendReq(RM, 1, 5);
        cyc = 0;
        while (!bus.fetch_valid && cyc < 10) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk("fetch before reset", int'(bus.fetch_valid), 1);
        @(negedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checkIdle("mid-fetch reset");
        @(posedge clock); #1;

        expReply(1, 1'b0, 2);                               doTxn(RM, 1, 5, 0, 0);
        expReply(2, 1'b1, 2);                               doTxn(WM, 2, 3, 0, 0);
        expReply(0, 1'b1, 2);                               doTxn(WM, 0, 6, 0, 0);

        repeat (3) @(negedge clock);
        chk("scoreboard drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
